// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//
// Memory-side responder for the CPU controller's memory command interface.
// A request presented while idle is latched (command, address, write data),
// held for WAIT_STATES cycles, then serviced against an internal DEPTH x DATA_W
// RAM. Completion is signalled by a one-cycle mem_ready pulse. Unmapped
// accesses complete normally but also pulse err_addr, discard writes and read
// back zero.
//
// Optional feature (macro MMIO_EN):
//   defined   : write to 0x100 loads led from data[7:0]; read of 0x140 returns
//               {zeros, sw} sampled in ACCESS. Neither address raises err_addr.
//   undefined : led is constant 0, sw is ignored, 0x100/0x140 are unmapped.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   mem_cmd    in   2'b00 MNONE, 2'b01 MREAD, 2'b10 MWRITE, 2'b11 as MNONE
//   mem_addr   in   word address (ADDR_W bits)
//   write_data in   store data (DATA_W bits)
//   read_data  out  load data, valid with mem_ready and held afterwards
//   mem_ready  out  one-cycle completion pulse
//   busy       out  high while a request is in flight
//   err_addr   out  one-cycle pulse with mem_ready on an unmapped access
//   sw         in   board switches (MMIO_EN only)
//   led        out  board LEDs (MMIO_EN only)
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter int WAIT_STATES = 1,
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 9,
    parameter int DEPTH       = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mem_cmd,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              mem_ready,
    output logic              busy,
    output logic              err_addr,
    input  logic [7:0]        sw,
    output logic [7:0]        led
);

    localparam int         IDX_W     = $clog2(DEPTH);
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    // Wait counter preload; WAIT is skipped entirely when WAIT_STATES is 0.
    localparam logic [3:0] WCNT_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic [1:0]        cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] read_data_q, read_data_d;
    logic [DATA_W-1:0] ram_q [DEPTH];

    logic              ram_we;
    logic [IDX_W-1:0]  ram_idx;
    logic              in_ram;
    logic              is_led;
    logic              is_sw;
    logic              mapped;

    // Decode always works on the latched address, never the live input.
    assign ram_idx = addr_q[IDX_W-1:0];
    assign in_ram  = (addr_q[ADDR_W-1:IDX_W] == '0);

`ifdef MMIO_EN
    localparam logic [ADDR_W-1:0] LED_ADDR = ADDR_W'('h100);
    localparam logic [ADDR_W-1:0] SW_ADDR  = ADDR_W'('h140);

    logic [7:0] led_q, led_d;

    assign is_led = (addr_q == LED_ADDR);
    assign is_sw  = (addr_q == SW_ADDR);
    assign led    = led_q;
`else
    logic unused_sw;

    assign is_led    = 1'b0;
    assign is_sw     = 1'b0;
    assign led       = 8'h00;
    assign unused_sw = ^sw;
`endif

    assign mapped = in_ram | is_led | is_sw;

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        data_d      = data_q;
        read_data_d = read_data_q;
        ram_we      = 1'b0;
`ifdef MMIO_EN
        led_d       = led_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (mem_cmd == CMD_READ || mem_cmd == CMD_WRITE) begin
                    cmd_d  = mem_cmd;
                    addr_d = mem_addr;
                    data_d = write_data;
                    if (WAIT_STATES == 0) begin
                        state_d = S_ACCESS;
                    end else begin
                        state_d = S_WAIT;
                        wcnt_d  = WCNT_INIT;
                    end
                end
            end

            S_WAIT: begin
                if (wcnt_q == 4'd0) begin
                    state_d = S_ACCESS;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end

            S_ACCESS: begin
                state_d = S_DONE;
                if (cmd_q == CMD_WRITE) begin
                    // Reset in this cycle must still win over the store.
                    ram_we = in_ram & ~reset;
`ifdef MMIO_EN
                    if (is_led) begin
                        led_d = data_q[7:0];
                    end
`endif
                end else begin
                    // Unmapped reads return zero.
                    read_data_d = '0;
                    if (in_ram) begin
                        read_data_d = ram_q[ram_idx];
                    end
`ifdef MMIO_EN
                    else if (is_sw) begin
                        read_data_d = {{(DATA_W-8){1'b0}}, sw};
                    end
`endif
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wcnt_q      <= 4'd0;
            cmd_q       <= 2'b00;
            addr_q      <= '0;
            data_q      <= '0;
            read_data_q <= '0;
`ifdef MMIO_EN
            led_q       <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            read_data_q <= read_data_d;
`ifdef MMIO_EN
            led_q       <= led_d;
`endif
        end
    end

    // NOTE: the RAM array has no reset; clearing it would turn it into a
    // register file and its contents are defined only by writes.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[ram_idx] <= data_q;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign mem_ready = (state_q == S_DONE);
    assign err_addr  = mem_ready & ~mapped;
    assign read_data = read_data_q;

endmodule
